alu_issue_decoder: RTL and testbench

Decode-and-issue stage that sits upstream of the datapath ALU and drives its 4-bit operation code and both operands. It accepts one MIPS instruction per handshake together with its register-file read data. It decodes the opcode/funct into the ALU operation code, selects and extends the operands, and presents a registered issue bundle to the ALU/execute stage over a valid/ready handshake. A 2-entry skid buffer lets upstream back-pressure be purely registered.

---
 rtl/alu_issue_decoder_pkg.sv | 50 +++++
 rtl/alu_issue_decoder_alu_op_decode.sv | 83 ++++++++
 rtl/alu_issue_decoder.sv | 117 +++++++++++
 tb/tb_alu_issue_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_decoder_pkg.sv
// ALU op codes, MIPS opcode/funct constants and the 75-bit issue bundle layout.
// Shared by the combinational decoder and the issue stage.
package alu_issue_decoder_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_NAND  = 4'd2,
        ALU_NOR   = 4'd3,
        ALU_ADDU  = 4'd4,
        ALU_SUBU  = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_EQUAL = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SRAV  = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_SLTU  = 4'd11
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam int ISSUE_W = 75;

    typedef struct packed {
        alu_op_e     ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  wb_reg;
        logic        wb_en;
        logic        illegal;
    } issue_t;

endpackage

// File: rtl/alu_issue_decoder_alu_op_decode.sv
// Purpose: decode one MIPS instruction plus register data into an ALU issue bundle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the bundle is captured.
module alu_op_decode
    import alu_issue_decoder_pkg::*;
(
    input  logic [31:0]        instr_i,
    input  logic [31:0]        rs_data_i,
    input  logic [31:0]        rt_data_i,
    output logic [ISSUE_W-1:0] bundle_o
);

    issue_t      b;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        unused_rs_idx;

    assign opcode   = instr_i[31:26];
    assign funct    = instr_i[5:0];
    assign imm_sext = {{16{instr_i[15]}}, instr_i[15:0]};
    assign imm_zext = {16'b0, instr_i[15:0]};

    // Operand data arrives already read from the register file.
    assign unused_rs_idx = ^instr_i[25:21];

    always_comb begin
        b      = '0;
        b.ctrl = ALU_AND;
        case (opcode)
            OP_RTYPE: begin
                b.src1   = rs_data_i;
                b.src2   = rt_data_i;
                b.wb_reg = instr_i[15:11];
                b.wb_en  = 1'b1;
                case (funct)
                    FN_AND:  b.ctrl = ALU_AND;
                    FN_OR:   b.ctrl = ALU_OR;
                    FN_NOR:  b.ctrl = ALU_NOR;
                    FN_ADDU: b.ctrl = ALU_ADDU;
                    FN_SUBU: b.ctrl = ALU_SUBU;
                    FN_SLT:  b.ctrl = ALU_SLT;
                    FN_SLTU: b.ctrl = ALU_SLTU;
                    FN_SRAV: b.ctrl = ALU_SRAV;
                    FN_SRA: begin
                        // ALU expects the immediate shift amount in src1[10:6].
                        b.ctrl = ALU_SRA;
                        b.src1 = {21'b0, instr_i[10:6], 6'b0};
                    end
                    default: begin
                        b         = '0;
                        b.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: begin
                b.src1   = rs_data_i;
                b.wb_reg = instr_i[20:16];
                b.wb_en  = 1'b1;
                case (opcode)
                    OP_ADDIU: begin b.ctrl = ALU_ADDU; b.src2 = imm_sext; end
                    OP_SLTI:  begin b.ctrl = ALU_SLT;  b.src2 = imm_sext; end
                    OP_SLTIU: begin b.ctrl = ALU_SLTU; b.src2 = imm_sext; end
                    OP_ANDI:  begin b.ctrl = ALU_AND;  b.src2 = imm_zext; end
                    OP_ORI:   begin b.ctrl = ALU_OR;   b.src2 = imm_zext; end
                    default:  begin b.ctrl = ALU_LUI;  b.src2 = imm_zext; end
                endcase
            end
            OP_BEQ: begin
                b.ctrl = ALU_EQUAL;
                b.src1 = rs_data_i;
                b.src2 = rt_data_i;
            end
            default: begin
                b.illegal = 1'b1;
            end
        endcase
    end

    assign bundle_o = b;

endmodule

// File: rtl/alu_issue_decoder.sv
// Purpose: decode-and-issue stage feeding the ALU with a registered bundle.
// Latency: one cycle from accept to valid_o when the output register is free.
// Backpressure: 2-entry skid; instr_ready_o depends on state only, never on ready_i.
module alu_issue_decoder
    import alu_issue_decoder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        flush_i,
    output logic [3:0]  ctrl_o,
    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [4:0]  wb_reg_o,
    output logic        wb_en_o,
    output logic        illegal_o,
    output logic        valid_o,
    input  logic        ready_i
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    issue_t             out_q, skid_q, dec_b;
    logic [ISSUE_W-1:0] dec_vec;
    logic               accept, out_xfer;
    logic               load_out_new, load_out_skid, load_skid;

    alu_op_decode u_dec (
        .instr_i   (instr_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .bundle_o  (dec_vec)
    );
    assign dec_b = issue_t'(dec_vec);

    assign instr_ready_o = (state_q != ST_FULL);
    assign valid_o       = (state_q != ST_EMPTY);
    assign accept        = instr_valid_i & instr_ready_o;
    assign out_xfer      = valid_o & ready_i;

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        load_out_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && out_xfer) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d       = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_new) begin
                out_q <= dec_b;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_b;
            end
        end
    end

    assign ctrl_o    = out_q.ctrl;
    assign src1_o    = out_q.src1;
    assign src2_o    = out_q.src2;
    assign wb_reg_o  = out_q.wb_reg;
    assign wb_en_o   = out_q.wb_en;
    assign illegal_o = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench with an expected-bundle scoreboard checked on every output transfer.
module tb_alu_issue_decoder;

    logic        clk_i;
    logic        rst_n;
    logic [31:0] instr_i, rs_data_i, rt_data_i;
    logic        instr_valid_i, instr_ready_o, flush_i;
    logic [3:0]  ctrl_o;
    logic [31:0] src1_o, src2_o;
    logic [4:0]  wb_reg_o;
    logic        wb_en_o, illegal_o, valid_o, ready_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [74:0] exp_q[$];
    string       tag_q[$];
    logic [74:0] exp_next;
    string       tag_next;

    alu_issue_decoder dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .instr_i       (instr_i),
        .rs_data_i     (rs_data_i),
        .rt_data_i     (rt_data_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .flush_i       (flush_i),
        .ctrl_o        (ctrl_o),
        .src1_o        (src1_o),
        .src2_o        (src2_o),
        .wb_reg_o      (wb_reg_o),
        .wb_en_o       (wb_en_o),
        .illegal_o     (illegal_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [74:0] mk(input logic [3:0] c, input logic [31:0] s1,
                                       input logic [31:0] s2, input logic [4:0] wr,
                                       input logic we, input logic il);
        return {c, s1, s2, wr, we, il};
    endfunction

    function automatic logic [74:0] obs_bundle();
        return {ctrl_o, src1_o, src2_o, wb_reg_o, wb_en_o, illegal_o};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Evaluate this cycle's handshakes just before the edge, then advance to edge+1.
    task automatic cycle();
        if (flush_i) begin
            exp_q.delete();
            tag_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 80'(valid_o), 80'(0));
                end else begin
                    check(tag_q.pop_front(), 80'(obs_bundle()), 80'(exp_q.pop_front()));
                end
            end
            if (instr_valid_i && instr_ready_o) begin
                exp_q.push_back(exp_next);
                tag_q.push_back(tag_next);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [74:0] e);
        instr_i       = ins;
        rs_data_i     = rs;
        rt_data_i     = rt;
        instr_valid_i = 1'b1;
        exp_next      = e;
        tag_next      = tag;
        cycle();
    endtask

    task automatic drain();
        int budget;
        instr_valid_i = 1'b0;
        ready_i       = 1'b1;
        budget        = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            cycle();
            budget++;
        end
        check("drain_empty", 80'(exp_q.size()), 80'(0));
    endtask

    initial begin
        rst_n = 1'b0; instr_i = '0; rs_data_i = '0; rt_data_i = '0;
        instr_valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        exp_next = '0; tag_next = "";
        #3;
        check("reset_state", 80'({obs_bundle(), valid_o, instr_ready_o}), 80'({75'b0, 1'b0, 1'b1}));
        #9 rst_n = 1'b1;
        @(posedge clk_i); #1;

        // Streaming with ready_i high: one issue per cycle.
        ready_i = 1'b1;
        issue("addu", 32'h00221821, 32'd5, 32'd7, mk(4'd4, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        check("addu_latency_valid", 80'(valid_o), 80'(1));
        issue("addiu_neg", 32'h2422FFFF, 32'd10, 32'd1, mk(4'd4, 32'd10, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b0));
        issue("ori_zext", 32'h34258000, 32'h1234, 32'd0, mk(4'd1, 32'h1234, 32'h00008000, 5'd5, 1'b1, 1'b0));
        issue("sra", 32'h000220C3, 32'h55, 32'h80000000, mk(4'd8, 32'h000000C0, 32'h80000000, 5'd4, 1'b1, 1'b0));
        issue("illegal_op", 32'hFC000000, 32'd1, 32'd2, mk(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
        issue("beq", 32'h10220004, 32'd3, 32'd3, mk(4'd7, 32'd3, 32'd3, 5'd0, 1'b0, 1'b0));
        issue("slti", 32'h2826FFF0, 32'd9, 32'd0, mk(4'd6, 32'd9, 32'hFFFFFFF0, 5'd6, 1'b1, 1'b0));
        issue("sltu", 32'h0022382B, 32'd1, 32'd2, mk(4'd11, 32'd1, 32'd2, 5'd7, 1'b1, 1'b0));
        issue("lui", 32'h3C08ABCD, 32'h99, 32'd0, mk(4'd10, 32'h99, 32'h0000ABCD, 5'd8, 1'b1, 1'b0));
        issue("srav", 32'h00224807, 32'd4, 32'hF0, mk(4'd9, 32'd4, 32'hF0, 5'd9, 1'b1, 1'b0));
        issue("nor", 32'h00225027, 32'hA, 32'hB, mk(4'd3, 32'hA, 32'hB, 5'd10, 1'b1, 1'b0));
        issue("subu", 32'h00225823, 32'hC, 32'hD, mk(4'd5, 32'hC, 32'hD, 5'd11, 1'b1, 1'b0));
        issue("and", 32'h00226024, 32'hE, 32'hF, mk(4'd0, 32'hE, 32'hF, 5'd12, 1'b1, 1'b0));
        issue("andi", 32'h302D8001, 32'h7, 32'd0, mk(4'd0, 32'h7, 32'h00008001, 5'd13, 1'b1, 1'b0));
        issue("sltiu", 32'h2C2E8000, 32'h8, 32'd0, mk(4'd11, 32'h8, 32'hFFFF8000, 5'd14, 1'b1, 1'b0));
        issue("slt", 32'h0022782A, 32'h11, 32'h22, mk(4'd6, 32'h11, 32'h22, 5'd15, 1'b1, 1'b0));
        issue("or", 32'h00228025, 32'h33, 32'h44, mk(4'd1, 32'h33, 32'h44, 5'd16, 1'b1, 1'b0));
        issue("bad_funct", 32'h00228800, 32'h55, 32'h66, mk(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
        drain();

        // Back-pressure: third instruction waits while the skid is occupied.
        ready_i = 1'b0;
        issue("bp_a", 32'h00221821, 32'd100, 32'd1, mk(4'd4, 32'd100, 32'd1, 5'd3, 1'b1, 1'b0));
        issue("bp_b", 32'h00225823, 32'd200, 32'd2, mk(4'd5, 32'd200, 32'd2, 5'd11, 1'b1, 1'b0));
        check("bp_full_ready_low", 80'(instr_ready_o), 80'(0));
        issue("bp_c", 32'h00226024, 32'd300, 32'd3, mk(4'd0, 32'd300, 32'd3, 5'd12, 1'b1, 1'b0));
        check("bp_still_full", 80'({valid_o, instr_ready_o}), 80'(2'b10));
        check("bp_output_held", 80'(obs_bundle()), 80'(exp_q[0]));
        ready_i = 1'b1;
        cycle();
        check("bp_c_pending", 80'(exp_q.size()), 80'(1));
        cycle();
        check("bp_c_taken", 80'(exp_q.size()), 80'(1));
        drain();

        // Flush while FULL discards buffered and same-cycle entries.
        ready_i = 1'b0;
        issue("fl_d", 32'h00221821, 32'd1, 32'd1, mk(4'd4, 32'd1, 32'd1, 5'd3, 1'b1, 1'b0));
        issue("fl_e", 32'h00221821, 32'd2, 32'd2, mk(4'd4, 32'd2, 32'd2, 5'd3, 1'b1, 1'b0));
        instr_i = 32'h00221821; instr_valid_i = 1'b1; flush_i = 1'b1;
        cycle();
        flush_i = 1'b0; instr_valid_i = 1'b0;
        check("flush_state", 80'({valid_o, instr_ready_o}), 80'(2'b01));
        ready_i = 1'b1;
        repeat (3) cycle();
        check("flush_idle", 80'(valid_o), 80'(0));

        // Asynchronous reset in the middle of a stall.
        ready_i = 1'b0;
        issue("rs_g", 32'h00228025, 32'h77, 32'h88, mk(4'd1, 32'h77, 32'h88, 5'd16, 1'b1, 1'b0));
        issue("rs_h", 32'h3C08ABCD, 32'h1, 32'h0, mk(4'd10, 32'h1, 32'hABCD, 5'd8, 1'b1, 1'b0));
        instr_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midstall_reset", 80'({obs_bundle(), valid_o, instr_ready_o}), 80'({75'b0, 1'b0, 1'b1}));
        exp_q.delete(); tag_q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        issue("post_reset", 32'h2422FFFF, 32'd42, 32'd0, mk(4'd4, 32'd42, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
